// File: rtl/axis_pkt_checker.sv
// AXI-stream packet checker: framing, strobe and length checks
// with a per-packet report and saturating traffic statistics.

module axis_pkt_checker #(
  parameter int AXIS_WIDTH    = 64,
  parameter int MIN_PKT_BYTES = 60,
  parameter int MAX_PKT_BYTES = 9600
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AXIS_WIDTH-1:0]   data,
  input  logic [AXIS_WIDTH/8-1:0] strb,
  input  logic                    valid,
  input  logic                    sop,
  input  logic                    eop,
  output logic                    ready,
  input  logic                    hold,
  output logic                    pkt_done,
  output logic [15:0]             pkt_len,
  output logic [15:0]             pkt_sum,
  output logic [4:0]              pkt_err,
  output logic [31:0]             good_pkts,
  output logic [31:0]             bad_pkts,
  output logic [47:0]             total_bytes,
  output logic [15:0]             orphan_beats
);

  localparam int NB = AXIS_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);

  localparam logic [16:0] MIN_L =
    17'(MIN_PKT_BYTES);
  localparam logic [16:0] MAX_L =
    17'(MAX_PKT_BYTES);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] sum;
    logic [4:0]  err;
  } rec_t;

  // err = {zero_strb, dup_sop, bad_strb, oversize, runt}
  function automatic rec_t mk_rec(
    input logic [15:0] len,
    input logic [15:0] sum,
    input logic        bad,
    input logic        zero,
    input logic        dup
  );
    rec_t r;
    r.len = len;
    r.sum = sum;
    r.err = {zero, dup, bad,
             {1'b0, len} > MAX_L,
             {1'b0, len} < MIN_L};
    return r;
  endfunction

  state_t state_q;
  state_t state_d;

  logic acc;

  logic [CW-1:0] beat_cnt;
  logic [15:0]   beat_sum;
  logic          beat_bad;
  logic          beat_zero;

  logic [15:0] acc_len;
  logic [15:0] acc_sum;
  logic        acc_bad;
  logic        acc_zero;

  logic [16:0] len_ext;
  logic [15:0] run_len;
  logic [15:0] run_sum;
  logic        run_bad;
  logic        run_zero;

  rec_t beat_rec;
  rec_t abort_rec;
  rec_t full_rec;

  logic ca;
  logic cb;
  rec_t rec_a;
  rec_t rec_b;
  logic ld_new;
  logic ld_add;
  logic orphan_inc;
  logic pkt_bytes;

  logic pend_v;
  rec_t pend;
  logic emit_v;
  rec_t emit_rec;
  logic pend_d_v;
  rec_t pend_d;

  logic [48:0] tot_ext;

  assign acc = valid & ready;

  always_comb begin
    beat_cnt = '0;
    beat_sum = '0;
    for (int k = 0; k < NB; k++) begin
      if (strb[k]) begin
        beat_cnt = beat_cnt + CW'(1);
        beat_sum = beat_sum
                 + 16'(data[8*k +: 8]);
      end
    end
    beat_zero = (strb == '0);
    // nonzero masks must be a low-aligned run;
    // only the last beat may be partial
    beat_bad =
      ((strb & (strb + NB'(1))) != '0) ||
      (!eop && (strb != '1));
  end

  assign len_ext  = {1'b0, acc_len}
                  + 17'(beat_cnt);
  assign run_len  = len_ext[16] ? '1
                  : len_ext[15:0];
  assign run_sum  = acc_sum + beat_sum;
  assign run_bad  = acc_bad | beat_bad;
  assign run_zero = acc_zero | beat_zero;

  assign beat_rec = mk_rec(
    16'(beat_cnt), beat_sum,
    beat_bad, beat_zero, 1'b0);
  assign abort_rec = mk_rec(
    acc_len, acc_sum,
    acc_bad, acc_zero, 1'b1);
  assign full_rec = mk_rec(
    run_len, run_sum,
    run_bad, run_zero, 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (sop && !eop) begin
            state_d = IN_PKT;
          end
        end
        IN_PKT: begin
          if (eop) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ca         = 1'b0;
    cb         = 1'b0;
    rec_a      = '0;
    rec_b      = '0;
    ld_new     = 1'b0;
    ld_add     = 1'b0;
    orphan_inc = 1'b0;
    pkt_bytes  = 1'b0;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            sop & eop: begin
              pkt_bytes = 1'b1;
              ca        = 1'b1;
              rec_a     = beat_rec;
            end
            sop & ~eop: begin
              pkt_bytes = 1'b1;
              ld_new    = 1'b1;
            end
            ~sop: begin
              orphan_inc = 1'b1;
            end
            default: ;
          endcase
        end
        IN_PKT: begin
          pkt_bytes = 1'b1;
          unique case (1'b1)
            sop & eop: begin
              ca    = 1'b1;
              rec_a = abort_rec;
              cb    = 1'b1;
              rec_b = beat_rec;
            end
            sop & ~eop: begin
              ca     = 1'b1;
              rec_a  = abort_rec;
              ld_new = 1'b1;
            end
            ~sop & eop: begin
              ca    = 1'b1;
              rec_a = full_rec;
            end
            ~sop & ~eop: begin
              ld_add = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_len  <= '0;
      acc_sum  <= '0;
      acc_bad  <= 1'b0;
      acc_zero <= 1'b0;
    end else if (ld_new) begin
      acc_len  <= 16'(beat_cnt);
      acc_sum  <= beat_sum;
      acc_bad  <= beat_bad;
      acc_zero <= beat_zero;
    end else if (ld_add) begin
      acc_len  <= run_len;
      acc_sum  <= run_sum;
      acc_bad  <= run_bad;
      acc_zero <= run_zero;
    end
  end

  // A pending report only exists while IDLE, where at most one
  // close per beat can arrive, so one slot never overflows.
  always_comb begin
    emit_v   = pend_v | ca;
    emit_rec = pend_v ? pend : rec_a;
    pend_d_v = pend_v ? ca : cb;
    pend_d   = pend_v ? rec_a : rec_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_sum  <= '0;
      pkt_err  <= '0;
      pend_v   <= 1'b0;
      pend     <= '0;
    end else begin
      ready    <= ~hold;
      pkt_done <= emit_v;
      pend_v   <= pend_d_v;
      pend     <= pend_d;
      if (emit_v) begin
        pkt_len <= emit_rec.len;
        pkt_sum <= emit_rec.sum;
        pkt_err <= emit_rec.err;
      end
    end
  end

  assign tot_ext = {1'b0, total_bytes}
                 + 49'(beat_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_pkts    <= '0;
      bad_pkts     <= '0;
      total_bytes  <= '0;
      orphan_beats <= '0;
    end else begin
      if (emit_v) begin
        if (emit_rec.err == '0) begin
          if (good_pkts != '1) begin
            good_pkts <= good_pkts + 32'd1;
          end
        end else if (bad_pkts != '1) begin
          bad_pkts <= bad_pkts + 32'd1;
        end
      end
      if (pkt_bytes) begin
        total_bytes <= tot_ext[48] ? '1
                     : tot_ext[47:0];
      end
      if (orphan_inc &&
          (orphan_beats != '1)) begin
        orphan_beats <= orphan_beats + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench for axis_pkt_checker: framing, strobe,
// backpressure and reset cases with hand-computed results.

module tb_axis_pkt_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data;
  logic [7:0]  strb;
  logic        valid;
  logic        sop;
  logic        eop;
  logic        ready;
  logic        hold;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic [15:0] pkt_sum;
  logic [4:0]  pkt_err;
  logic [31:0] good_pkts;
  logic [31:0] bad_pkts;
  logic [47:0] total_bytes;
  logic [15:0] orphan_beats;

  always #5 clk = ~clk;

  axis_pkt_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .strb         (strb),
    .valid        (valid),
    .sop          (sop),
    .eop          (eop),
    .ready        (ready),
    .hold         (hold),
    .pkt_done     (pkt_done),
    .pkt_len      (pkt_len),
    .pkt_sum      (pkt_sum),
    .pkt_err      (pkt_err),
    .good_pkts    (good_pkts),
    .bad_pkts     (bad_pkts),
    .total_bytes  (total_bytes),
    .orphan_beats (orphan_beats)
  );

  typedef struct {
    int len;
    int sum;
    int err;
    int cyc;
  } rec_t;

  rec_t rq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && pkt_done === 1'b1) begin
      rq.push_back('{int'(pkt_len), int'(pkt_sum),
                     int'(pkt_err), cyc});
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic pop_rec(input string tag,
                         input int len,
                         input int sum,
                         input int err,
                         output int c);
    rec_t r;
    c = -1;
    if (rq.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      r = rq.pop_front();
      check({tag, "_len"}, r.len, len);
      check({tag, "_sum"}, r.sum, sum);
      check({tag, "_err"}, r.err, err);
      c = r.cyc;
    end
  endtask

  task automatic check_none(input string tag);
    check({tag, "_extra_done"}, rq.size(), 0);
  endtask

  function automatic logic [63:0] fill(
    input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic send(input logic [63:0] d,
                      input logic [7:0] s,
                      input logic so,
                      input logic eo);
    @(negedge clk);
    data  = d;
    strb  = s;
    sop   = so;
    eop   = eo;
    valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      sop   = 1'b0;
      eop   = 1'b0;
    end
  endtask

  task automatic send_inc_pkt();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        d[8*k +: 8] = 8'(8 * i + k);
      end
      send(d, 8'hFF, i == 0, i == 7);
    end
  endtask

  initial begin
    int c1;
    int c2;
    int c3;
    rst_n = 1'b0;
    hold  = 1'b0;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    data  = '0;
    strb  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_done", pkt_done, 0);
    check("rst_len", pkt_len, 0);
    check("rst_good", good_pkts, 0);
    check("rst_total", total_bytes, 0);
    check("rst_orphan", orphan_beats, 0);
    rst_n = 1'b1;
    idle(2);
    check("ready_up", ready, 1);

    // 64-byte packet, bytes 0..63
    send_inc_pkt();
    idle(3);
    pop_rec("t1", 64, 2016, 0, c1);
    check_none("t1");
    check("t1_good", good_pkts, 1);
    check("t1_bad", bad_pkts, 0);
    check("t1_total", total_bytes, 64);

    // single-beat runt, masked lanes ignored
    send(64'hFFFF_FFFF_FF30_2010, 8'h07, 1, 1);
    idle(3);
    pop_rec("t2", 3, 96, 1, c1);
    check("t2_bad", bad_pkts, 1);
    check("t2_good", good_pkts, 1);
    check("t2_total", total_bytes, 67);

    // duplicate sop after two beats
    send(fill(8'h01), 8'hFF, 1, 0);
    send(fill(8'h01), 8'hFF, 0, 0);
    send(fill(8'h02), 8'hFF, 1, 0);
    for (int i = 0; i < 6; i++) begin
      send(fill(8'h02), 8'hFF, 0, 0);
    end
    send(fill(8'h02), 8'hFF, 0, 1);
    idle(3);
    pop_rec("t3a", 16, 16, 9, c1);
    pop_rec("t3b", 64, 128, 0, c2);
    check("t3_good", good_pkts, 2);
    check("t3_bad", bad_pkts, 2);
    check("t3_total", total_bytes, 147);

    // non-contiguous strobe on the eop beat
    for (int i = 0; i < 8; i++) begin
      send(fill(8'h03), 8'hFF, i == 0, 0);
    end
    send(64'h0000_0000_0455_0201, 8'h0B, 0, 1);
    idle(3);
    pop_rec("t4", 67, 199, 4, c1);
    check("t4_bad", bad_pkts, 3);
    check("t4_total", total_bytes, 214);

    // dup sop with eop, then an immediate single beat
    send(fill(8'h05), 8'hFF, 1, 0);
    send(fill(8'h06), 8'hFF, 1, 1);
    send(fill(8'h07), 8'h0F, 1, 1);
    idle(4);
    pop_rec("t5c", 8, 40, 9, c1);
    pop_rec("t5d", 8, 48, 1, c2);
    pop_rec("t5e", 4, 28, 1, c3);
    check("t5_gap_cd", c2 - c1, 1);
    check("t5_gap_de", c3 - c2, 1);
    check("t5_bad", bad_pkts, 6);
    check("t5_good", good_pkts, 2);
    check("t5_total", total_bytes, 234);

    // orphans, then backpressure
    for (int i = 0; i < 3; i++) begin
      send(fill(8'h09), 8'hFF, 0, i == 2);
    end
    idle(2);
    check("t6_orphan", orphan_beats, 3);
    check("t6_total", total_bytes, 234);
    check_none("t6");
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    check("t6_hold_ready", ready, 0);
    for (int i = 0; i < 3; i++) begin
      send(fill(8'h01), 8'hFF, 1, 1);
    end
    send(fill(8'h01), 8'hFF, 0, 0);
    @(negedge clk);
    valid = 1'b0;
    hold  = 1'b0;
    idle(3);
    check_none("t6h");
    check("t6h_orphan", orphan_beats, 3);
    check("t6h_bad", bad_pkts, 6);
    check("t6h_total", total_bytes, 234);
    check("t6h_ready", ready, 1);

    // reset in the middle of a packet
    send(fill(8'h01), 8'hFF, 1, 0);
    send(fill(8'h01), 8'hFF, 0, 0);
    send(fill(8'h01), 8'hFF, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_ready", ready, 0);
    check("t7_done", pkt_done, 0);
    check("t7_len", pkt_len, 0);
    check("t7_sum", pkt_sum, 0);
    check("t7_err", pkt_err, 0);
    check("t7_good", good_pkts, 0);
    check("t7_bad", bad_pkts, 0);
    check("t7_total", total_bytes, 0);
    check("t7_orphan", orphan_beats, 0);
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_none("t7_partial");
    send_inc_pkt();
    idle(3);
    pop_rec("t7p", 64, 2016, 0, c1);
    check_none("t7p");
    check("t7p_good", good_pkts, 1);
    check("t7p_bad", bad_pkts, 0);
    check("t7p_total", total_bytes, 64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_checker.md
AXIS_PKT_CHECKER -- requirements
Module: axis_pkt_checker

Interface
REQ-001 SHALL have parameter AXIS_WIDTH, default 64, stream data width in bits; a multiple of 8, from 16 to 512.
REQ-002 SHALL have parameter MIN_PKT_BYTES, default 60, minimum legal packet length in bytes.
REQ-003 SHALL have parameter MAX_PKT_BYTES, default 9600, maximum legal packet length in bytes; less than 65536.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; asynchronous assertion, active-low.
REQ-006 SHALL have port data, input, AXIS_WIDTH bits, beat payload; byte lane k is data[8k+7:8k].
REQ-007 SHALL have port strb, input, AXIS_WIDTH/8 bits, byte-lane valid mask; bit k qualifies lane k.
REQ-008 SHALL have port valid, input, 1 bit, beat present.
REQ-009 SHALL have port sop, input, 1 bit, first beat of a packet.
REQ-010 SHALL have port eop, input, 1 bit, last beat of a packet.
REQ-011 SHALL have port ready, output, 1 bit, the checker accepts the beat.
REQ-012 SHALL have port hold, input, 1 bit, backpressure request from the bench.
REQ-013 SHALL have port pkt_done, output, 1 bit, one-cycle pulse when a packet closes.
REQ-014 SHALL have port pkt_len, output, 16 bits, byte length of the closed packet.
REQ-015 SHALL have port pkt_sum, output, 16 bits, modulo-2^16 sum of all valid bytes of the closed packet.
REQ-016 SHALL have port pkt_err, output, 5 bits, error flags of the closed packet: bit0 runt, bit1 oversize, bit2 bad_strb, bit3 dup_sop, bit4 zero_strb.
REQ-017 SHALL have port good_pkts, output, 32 bits, count of closed packets with pkt_err==0.
REQ-018 SHALL have port bad_pkts, output, 32 bits, count of closed packets with pkt_err!=0.
REQ-019 SHALL have port total_bytes, output, 48 bits, count of all valid bytes accepted inside packets.
REQ-020 SHALL have port orphan_beats, output, 16 bits, count of beats accepted outside a packet.

Function
REQ-021 SHALL define an accepted beat as valid && ready in the same cycle; only accepted beats are examined.
REQ-022 SHALL drive ready as a register loaded with ~hold every cycle, so backpressure takes effect one cycle after hold changes.
REQ-023 SHALL implement an FSM with states IDLE and IN_PKT, entering IDLE on reset.
REQ-024 SHALL move IDLE->IN_PKT on an accepted beat with sop=1 and eop=0.
REQ-025 SHALL close the packet on an accepted beat with sop=1 and eop=1 in IDLE, and stay in IDLE.
REQ-026 SHALL, in IDLE, treat an accepted beat with sop=0 as an orphan: increment orphan_beats, add nothing to any packet, emit no pkt_done.
REQ-027 SHALL move IN_PKT->IDLE on an accepted beat with eop=1, closing the packet with that beat included.
REQ-028 SHALL, in IN_PKT, handle an accepted beat with sop=1 as follows: close the current packet without that beat and with dup_sop set, then start a new packet with that beat (stay in IN_PKT, or close the new packet too if eop=1 -- see REQ-037).
REQ-029 SHALL take a beat's byte count as the popcount of strb, and a beat's sum as the sum of data bytes in lanes whose strb bit is 1.
REQ-030 SHALL set bad_strb when strb is nonzero and not of the form 2^n-1, or when strb is not all-ones on a beat with eop=0; such beats still count their set lanes.
REQ-031 SHALL set zero_strb for any beat in the packet with strb==0.
REQ-032 SHALL, when closing a packet, set runt if its length < MIN_PKT_BYTES and oversize if its length > MAX_PKT_BYTES.
REQ-033 SHALL saturate the internal length at 65535; pkt_sum wraps modulo 2^16.
REQ-034 SHALL register pkt_done, pkt_len, pkt_sum and pkt_err one cycle after the closing beat is accepted.
REQ-035 SHALL hold pkt_len, pkt_sum and pkt_err until the next close; pkt_done is high for exactly one cycle per close.
REQ-036 SHALL update good_pkts or bad_pkts in the same cycle that pkt_done is asserted.
REQ-037 SHALL, when two closes occur in one beat (dup_sop beat that also has eop=1), report the aborted packet on the first pulse and the new single-beat packet on the following cycle's pulse.
REQ-038 SHALL saturate all counters at all-ones rather than wrapping.

Reset
REQ-039 SHALL, while rst_n=0, force ready=0, pkt_done=0, pkt_len=0, pkt_sum=0, pkt_err=0, all counters to 0, and the FSM to IDLE, asynchronously.
REQ-040 SHALL discard any partial packet on reset, with no pkt_done emitted for it.

Verification
REQ-041 Bench SHALL drive a 64-byte packet as 8 full beats (bytes 0..63), sop on beat 0 and eop on beat 7 -> one pkt_done, pkt_len=64, pkt_sum=2016, pkt_err=0, good_pkts=1.
REQ-042 Bench SHALL drive a single beat with sop=eop=1 and strb=8'h07 -> pkt_len=3, pkt_err=5'b00001 (runt), bad_pkts=1.
REQ-043 Bench SHALL drive sop again mid-packet after 2 full beats -> first pkt_done with pkt_len=16 and pkt_err bit3 set; the new packet continues normally.
REQ-044 Bench SHALL drive strb=8'h0B on an eop beat -> bad_strb set and pkt_len including 3 bytes for that beat.
REQ-045 Bench SHALL drive 3 beats with no sop -> orphan_beats=3 and no pkt_done; then hold=1 -> ready=0 on the next cycle and no beats counted.
REQ-046 Bench SHALL assert rst_n=0 mid-packet -> all outputs 0 immediately; after release, a fresh 64-byte packet reports pkt_err=0.
